// File: rtl/cpu_sram_responder.sv
// cpu_sram_responder: dual-port byte-write RAM (1-cycle reads) plus LED/NUM/TIMER/SWITCH MMIO on the data port; ports: clk, rst (async active-low), inst_sram_* (read-only), data_sram_*, switch_in, led_out, num_out
module cpu_sram_responder #(
  parameter int          ADDR_W     = 14,
  parameter logic [15:0] MMIO_BASE  = 16'hBFAF,
  parameter logic [31:0] TIMER_STEP = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);
  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_NUM    = 16'hF010;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_SWITCH = 16'hF020;
  logic [31:0]       r_mem [2**ADDR_W];
  logic [31:0]       r_inst_rdata, r_data_rdata, r_num, r_timer;
  logic [15:0]       r_led;
  logic [ADDR_W-1:0] w_iidx, w_didx;
  logic [15:0]       w_off;
  logic              w_mmio, w_rd, w_wr, w_ram_wr, w_mmio_wr;
  logic [31:0]       w_wmask, w_mmio_rdata, w_num_nxt, w_timer_wr;
  logic [15:0]       w_led_nxt;
  logic              w_unused;
  assign w_iidx    = inst_sram_addr[ADDR_W+1:2];
  assign w_didx    = data_sram_addr[ADDR_W+1:2];
  assign w_off     = data_sram_addr[15:0];
  assign w_mmio    = data_sram_addr[31:16] == MMIO_BASE;
  assign w_rd      = data_sram_en && data_sram_wen == 4'b0000;
  assign w_wr      = data_sram_en && data_sram_wen != 4'b0000;
  assign w_ram_wr  = rst && w_wr && !w_mmio;
  assign w_mmio_wr = w_wr && w_mmio;
  assign w_wmask   = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}}, {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};
  assign w_led_nxt  = (r_led & ~w_wmask[15:0]) | (data_sram_wdata[15:0] & w_wmask[15:0]);
  assign w_num_nxt  = (r_num & ~w_wmask) | (data_sram_wdata & w_wmask);
  assign w_timer_wr = (r_timer & ~w_wmask) | (data_sram_wdata & w_wmask);
  assign w_unused  = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0]};
  always_comb
    w_mmio_rdata = w_off == OFF_LED    ? {16'h0, r_led}     :
                   w_off == OFF_NUM    ? r_num              :
                   w_off == OFF_TIMER  ? r_timer            :
                   w_off == OFF_SWITCH ? {16'h0, switch_in} : 32'h0;
  // write port: byte-lane writes; a write held off by reset never lands
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (w_ram_wr && data_sram_wen[i]) r_mem[w_didx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  // reads sample r_mem before this edge's write, so same-word inst reads see the old word
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_inst_rdata <= 32'h0;
      r_data_rdata <= 32'h0;
      r_led        <= 16'h0;
      r_num        <= 32'h0;
      r_timer      <= 32'h0;
    end else begin
      if (inst_sram_en) r_inst_rdata <= r_mem[w_iidx];
      if (w_rd) r_data_rdata <= w_mmio ? w_mmio_rdata : r_mem[w_didx];
      if (w_mmio_wr && w_off == OFF_LED) r_led <= w_led_nxt;
      if (w_mmio_wr && w_off == OFF_NUM) r_num <= w_num_nxt;
      r_timer <= w_mmio_wr && w_off == OFF_TIMER ? w_timer_wr : r_timer + TIMER_STEP;
    end
  assign inst_sram_rdata = r_inst_rdata;
  assign data_sram_rdata = r_data_rdata;
  assign led_out         = r_led;
  assign num_out         = r_num;
endmodule

// File: tb/tb_cpu_sram_responder.sv
// tb_cpu_sram_responder: randomized scoreboard bench for cpu_sram_responder against a word-level reference model
module tb_cpu_sram_responder;
  localparam int          AW   = 14;
  localparam logic [31:0] STEP = 32'd1;
  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_sram_en = 1'b0, data_sram_en = 1'b0;
  logic [3:0]  inst_sram_wen = 4'h0, data_sram_wen = 4'h0;
  logic [31:0] inst_sram_addr = 32'h0, inst_sram_wdata = 32'h0, data_sram_addr = 32'h0, data_sram_wdata = 32'h0;
  logic [15:0] switch_in = 16'h0;
  logic [31:0] inst_sram_rdata, data_sram_rdata, num_out;
  logic [15:0] led_out;
  cpu_sram_responder dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .switch_in(switch_in), .led_out(led_out), .num_out(num_out)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] i; logic [31:0] d; logic [31:0] num; logic [15:0] led;} exp_t;
  exp_t        q[$];
  logic [31:0] m_mem [2**AW];
  logic [31:0] m_i = 32'h0, m_d = 32'h0, m_num = 32'h0, m_timer = 32'h0;
  logic [15:0] m_led = 16'h0;
  logic [15:0] offs [5] = '{16'hF000, 16'hF010, 16'hE000, 16'hF020, 16'hF030};
  int          errors = 0, checks = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction
  function automatic logic [31:0] mmio_rd(input logic [15:0] off, input logic [15:0] sw);
    case (off)
      16'hF000: return {16'h0, m_led};
      16'hF010: return m_num;
      16'hE000: return m_timer;
      16'hF020: return {16'h0, sw};
      default:  return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] ram_addr(input int idx);
    logic [31:0] r;
    r = $urandom;
    r[AW+1:2] = AW'(idx);
    if (r[31:16] == 16'hBFAF) r[31] = 1'b0;
    return r;
  endfunction
  // called at a negedge: drives one request cycle, predicts its outcome, queues it, advances to the next negedge
  task automatic cyc(input logic ie, input logic [31:0] ia, input logic de, input logic [3:0] dw,
                     input logic [31:0] da, input logic [31:0] dwd, input logic [15:0] sw);
    logic        mm, tw;
    logic [31:0] t;
    mm = da[31:16] == 16'hBFAF;
    tw = 1'b0;
    inst_sram_en = ie; inst_sram_addr = ia; inst_sram_wen = 4'($urandom); inst_sram_wdata = $urandom;
    data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dwd; switch_in = sw;
    if (ie) m_i = m_mem[ia[AW+1:2]];
    if (de && dw == 4'h0) m_d = mm ? mmio_rd(da[15:0], sw) : m_mem[da[AW+1:2]];
    if (de && dw != 4'h0) begin
      if (!mm) m_mem[da[AW+1:2]] = merge(m_mem[da[AW+1:2]], dwd, dw);
      else if (da[15:0] == 16'hF000) begin
        t = merge({16'h0, m_led}, dwd, dw & 4'b0011);
        m_led = t[15:0];
      end else if (da[15:0] == 16'hF010) m_num = merge(m_num, dwd, dw);
      else if (da[15:0] == 16'hE000) begin
        m_timer = merge(m_timer, dwd, dw);
        tw = 1'b1;
      end
    end
    if (!tw) m_timer = m_timer + STEP;
    q.push_back('{i: m_i, d: m_d, num: m_num, led: m_led});
    @(negedge clk);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("inst_rdata", inst_sram_rdata, e.i);
        chk("data_rdata", data_sram_rdata, e.d);
        chk("led_out", {16'h0, led_out}, {16'h0, e.led});
        chk("num_out", num_out, e.num);
      end
    end
  end
  initial begin
    #1 rst = 1'b0;
    #1;
    chk("reset_inst", inst_sram_rdata, 32'h0);
    chk("reset_data", data_sram_rdata, 32'h0);
    chk("reset_led", {16'h0, led_out}, 32'h0);
    chk("reset_num", num_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 16'h0);
    cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_E000, 32'h0, 16'h0);
    cyc(1'b0, 32'h0, 1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 16'h0);
    cyc(1'b0, 32'h0, 1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AB00, 16'h0);
    cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0010, 32'h0, 16'h0);
    cyc(1'b1, 32'h10, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0);
    cyc(1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0, 16'h0);
    cyc(1'b0, 32'h0, 1'b1, 4'b0011, 32'hBFAF_F000, 32'h0000_00A5, 16'h0);
    cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_F020, 32'h0, 16'h5A5A);
    cyc(1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAF_F010, 32'h1357_9BDF, 16'h0);
    cyc(1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE, 16'h0);
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_E000, 32'h0, 16'h0);
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h10;
    inst_sram_en = 1'b1; inst_sram_addr = 32'h10;
    #2 rst = 1'b0;
    #1;
    chk("midrst_inst", inst_sram_rdata, 32'h0);
    chk("midrst_data", data_sram_rdata, 32'h0);
    chk("midrst_led", {16'h0, led_out}, 32'h0);
    chk("midrst_num", num_out, 32'h0);
    m_i = 32'h0; m_d = 32'h0; m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0;
    inst_sram_en = 1'b0; data_sram_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0010, 32'h0, 16'h0);
    for (int k = 0; k < 16; k++) cyc(1'b0, 32'h0, 1'b1, 4'hF, ram_addr(k), $urandom, 16'h0);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] da;
      logic [3:0]  dw;
      dw = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
      da = $urandom_range(0, 2) == 0 ? {16'hBFAF, offs[$urandom_range(0, 4)]} : ram_addr($urandom_range(0, 15));
      cyc(1'($urandom), ram_addr($urandom_range(0, 15)), $urandom_range(0, 3) != 0, dw, da, $urandom, 16'($urandom));
    end
    cyc(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 16'h0);
    @(negedge clk);
    if (q.size() != 0) chk("queue_drain", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
